// File: rtl/wb_router_pkg.sv
// Shared definitions for the host Wishbone router: FSM encoding, region ID
// width and the default region IDs of the known targets.
package wb_router_pkg;

    localparam int REGION_W = 8;

    localparam logic [REGION_W-1:0] USER_SPACE_CARAVEL = 8'h30;
    localparam logic [REGION_W-1:0] HOST_PERIPHERAL    = 8'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/wb_router_timer.sv
// Response timeout counter: counts cycles while enabled and flags expiry on the
// TIMEOUT_CYCLES-th enabled cycle. TIMEOUT_CYCLES = 0 never expires.
module wb_router_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The count holds completed wait cycles, so expiry compares against one less.
    localparam logic [TIMEOUT_W-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && en && (count == LIMIT);

endmodule

// File: rtl/wb_host_router.sv
// Routes single Wishbone transactions from the management core to one of
// N_TARGETS master channels, selected by the region ID in the top address byte.
module wb_host_router
    import wb_router_pkg::*;
#(
    parameter int                        N_TARGETS      = 2,
    parameter int                        ADDR_W         = 32,
    parameter int                        DATA_W         = 32,
    parameter logic [N_TARGETS*8-1:0]    TARGET_IDS     = {HOST_PERIPHERAL, USER_SPACE_CARAVEL},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter int                        TIMEOUT_W      = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_we_i,
    input  logic [DATA_W/8-1:0]           wbs_sel_i,
    input  logic [ADDR_W-1:0]             wbs_adr_i,
    input  logic [DATA_W-1:0]             wbs_data_i,
    output logic                          wbs_ack_o,
    output logic                          wbs_err_o,
    output logic                          wbs_stall_o,
    output logic [DATA_W-1:0]             wbs_data_o,
    output logic [N_TARGETS-1:0]          m_wb_cyc_o,
    output logic [N_TARGETS-1:0]          m_wb_stb_o,
    output logic                          m_wb_we_o,
    output logic [DATA_W/8-1:0]           m_wb_sel_o,
    output logic [ADDR_W-9:0]             m_wb_adr_o,
    output logic [DATA_W-1:0]             m_wb_data_o,
    input  logic [N_TARGETS-1:0]          m_wb_ack_i,
    input  logic [N_TARGETS-1:0]          m_wb_err_i,
    input  logic [N_TARGETS-1:0]          m_wb_stall_i,
    input  logic [N_TARGETS*DATA_W-1:0]   m_wb_data_i,
    output logic                          timeout_o
);

    localparam int MADR_W = ADDR_W - REGION_W;

    state_t                 state;
    logic [N_TARGETS-1:0]   tgt_hot;
    logic [N_TARGETS-1:0]   hit_hot;
    logic [REGION_W-1:0]    region;
    logic                   tgt_ack;
    logic                   tgt_err;
    logic                   tgt_stall;
    logic [DATA_W-1:0]      tgt_rdata;
    logic                   expired;

    assign region = wbs_adr_i[ADDR_W-1 -: REGION_W];

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_hot = '0;
        for (int i = N_TARGETS - 1; i >= 0; i--) begin
            if (region == TARGET_IDS[REGION_W*i +: REGION_W]) begin
                hit_hot    = '0;
                hit_hot[i] = 1'b1;
            end
        end
    end

    assign tgt_ack   = |(m_wb_ack_i   & tgt_hot);
    assign tgt_err   = |(m_wb_err_i   & tgt_hot);
    assign tgt_stall = |(m_wb_stall_i & tgt_hot);

    always_comb begin
        tgt_rdata = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (tgt_hot[i]) begin
                tgt_rdata = tgt_rdata | m_wb_data_i[DATA_W*i +: DATA_W];
            end
        end
    end

    wb_router_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            tgt_hot     <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            wbs_stall_o <= 1'b0;
            wbs_data_o  <= '0;
            m_wb_cyc_o  <= '0;
            m_wb_stb_o  <= '0;
            m_wb_we_o   <= 1'b0;
            m_wb_sel_o  <= '0;
            m_wb_adr_o  <= '0;
            m_wb_data_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_data_o <= '0;
            timeout_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        m_wb_we_o   <= wbs_we_i;
                        m_wb_sel_o  <= wbs_sel_i;
                        m_wb_adr_o  <= wbs_adr_i[MADR_W-1:0];
                        m_wb_data_o <= wbs_data_i;
                        tgt_hot     <= hit_hot;
                        wbs_stall_o <= 1'b1;
                        if (|hit_hot) begin
                            m_wb_cyc_o <= hit_hot;
                            m_wb_stb_o <= hit_hot;
                            state      <= REQ;
                        end else begin
                            wbs_err_o <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                REQ, WAIT: begin
                    if (!wbs_cyc_i) begin
                        // Master gave up: abandon silently, any same-cycle ack is dropped.
                        m_wb_cyc_o  <= '0;
                        m_wb_stb_o  <= '0;
                        wbs_stall_o <= 1'b0;
                        state       <= IDLE;
                    end else if (state == WAIT || !tgt_stall) begin
                        m_wb_stb_o <= '0;
                        if (tgt_err) begin
                            m_wb_cyc_o <= '0;
                            wbs_err_o  <= 1'b1;
                            state      <= RESP;
                        end else if (tgt_ack) begin
                            m_wb_cyc_o <= '0;
                            wbs_ack_o  <= 1'b1;
                            wbs_data_o <= tgt_rdata;
                            state      <= RESP;
                        end else if (expired) begin
                            m_wb_cyc_o <= '0;
                            wbs_err_o  <= 1'b1;
                            timeout_o  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                RESP: begin
                    wbs_stall_o <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_router.sv
// Directed bench for wb_host_router with two targets and a 4-cycle timeout.
module tb_wb_host_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack;
    logic        err;
    logic        stall;
    logic [31:0] rdata;
    logic [1:0]  m_cyc;
    logic [1:0]  m_stb;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [23:0] m_adr;
    logic [31:0] m_wdata;
    logic [1:0]  m_ack   = 2'b00;
    logic [1:0]  m_err   = 2'b00;
    logic [1:0]  m_stall = 2'b00;
    logic [63:0] m_rdata = 64'h0;
    logic        timeout;

    int vectors     = 0;
    int miscompares = 0;

    wb_host_router #(
        .N_TARGETS      (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TARGET_IDS     ({8'h3F, 8'h30}),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_W      (8)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_data_i   (wdata),
        .wbs_ack_o    (ack),
        .wbs_err_o    (err),
        .wbs_stall_o  (stall),
        .wbs_data_o   (rdata),
        .m_wb_cyc_o   (m_cyc),
        .m_wb_stb_o   (m_stb),
        .m_wb_we_o    (m_we),
        .m_wb_sel_o   (m_sel),
        .m_wb_adr_o   (m_adr),
        .m_wb_data_o  (m_wdata),
        .m_wb_ack_i   (m_ack),
        .m_wb_err_i   (m_err),
        .m_wb_stall_i (m_stall),
        .m_wb_data_i  (m_rdata),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = a;
        wdata = d;
        sel   = s;
    endtask

    int stb_cycles;
    int ack_count;
    int err_count;
    int stall_cycles;
    int err_at;
    int tmo_at;
    logic [1:0] cyc_at_err;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mcyc", {30'b0, m_cyc}, 32'h0);
        check("rst_mstb", {30'b0, m_stb}, 32'h0);
        check("rst_timeout", {31'b0, timeout}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_madr", {8'h0, m_adr}, 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait read from target 0
        request(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        m_rdata[31:0] = 32'hDEAD_BEEF;
        m_ack = 2'b01;
        tick();
        stb = 1'b0;
        check("rd_mstb_t1", {30'b0, m_stb}, 32'h1);
        check("rd_mcyc_t1", {30'b0, m_cyc}, 32'h1);
        check("rd_madr_t1", {8'h0, m_adr}, 32'h0000_0010);
        check("rd_stall_t1", {31'b0, stall}, 32'h1);
        check("rd_ack_t1", {31'b0, ack}, 32'h0);
        tick();
        check("rd_ack_t2", {31'b0, ack}, 32'h1);
        check("rd_data_t2", rdata, 32'hDEAD_BEEF);
        check("rd_err_t2", {31'b0, err}, 32'h0);
        check("rd_mcyc_t2", {30'b0, m_cyc}, 32'h0);
        m_ack = 2'b00;
        cyc = 1'b0;
        tick();
        check("rd_ack_t3", {31'b0, ack}, 32'h0);
        check("rd_stall_t3", {31'b0, stall}, 32'h0);
        tick();

        // Write to target 1: stalled 3 cycles, ack 2 cycles after acceptance
        request(1'b1, 32'h3F00_0004, 32'h1234_5678, 4'b0011);
        m_stall = 2'b10;
        tick();
        stb = 1'b0;
        check("wr_mwe", {31'b0, m_we}, 32'h1);
        check("wr_msel", {28'b0, m_sel}, 32'h3);
        check("wr_madr", {8'h0, m_adr}, 32'h0000_0004);
        check("wr_mdata", m_wdata, 32'h1234_5678);
        check("wr_mcyc", {30'b0, m_cyc}, 32'h2);
        stb_cycles = 0; ack_count = 0; err_count = 0; stall_cycles = 0;
        for (int c = 1; c <= 8; c++) begin
            if (m_stb[1]) stb_cycles++;
            if (ack) ack_count++;
            if (err) err_count++;
            if (stall) stall_cycles++;
            m_stall = (c <= 3) ? 2'b10 : 2'b00;
            m_ack   = (c == 6) ? 2'b10 : 2'b00;
            tick();
        end
        check("wr_stb_cycles", stb_cycles, 32'd4);
        check("wr_ack_count", ack_count, 32'd1);
        check("wr_err_count", err_count, 32'd0);
        check("wr_stall_cycles", stall_cycles, 32'd7);
        cyc = 1'b0;
        tick();

        // Decode miss
        request(1'b0, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        tick();
        stb = 1'b0;
        check("miss_err_t1", {31'b0, err}, 32'h1);
        check("miss_ack_t1", {31'b0, ack}, 32'h0);
        check("miss_mcyc_t1", {30'b0, m_cyc}, 32'h0);
        check("miss_data_t1", rdata, 32'h0);
        cyc = 1'b0;
        tick();
        check("miss_err_t2", {31'b0, err}, 32'h0);
        check("miss_mcyc_t2", {30'b0, m_cyc}, 32'h0);
        tick();

        // Timeout: target 0 never answers in time, then acks late
        request(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        stb = 1'b0;
        err_at = 0; tmo_at = 0; ack_count = 0; err_count = 0; cyc_at_err = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            if (err) begin
                err_count++;
                err_at = c;
                cyc_at_err = m_cyc;
            end
            if (timeout) tmo_at = c;
            if (ack) ack_count++;
            m_ack = (c == 8) ? 2'b01 : 2'b00;
            tick();
        end
        check("tmo_err_cycle", err_at, 32'd6);
        check("tmo_pulse_cycle", tmo_at, 32'd6);
        check("tmo_err_count", err_count, 32'd1);
        check("tmo_late_ack", ack_count, 32'd0);
        check("tmo_mcyc", {30'b0, cyc_at_err}, 32'h0);
        cyc = 1'b0;
        tick();

        // Ack and err together: err wins
        request(1'b0, 32'h3F00_0008, 32'h0, 4'hF);
        m_rdata[63:32] = 32'h5555_AAAA;
        tick();
        stb = 1'b0;
        m_ack = 2'b10;
        m_err = 2'b10;
        tick();
        check("both_err", {31'b0, err}, 32'h1);
        check("both_ack", {31'b0, ack}, 32'h0);
        check("both_data", rdata, 32'h0);
        m_ack = 2'b00;
        m_err = 2'b00;
        cyc = 1'b0;
        tick();

        // Master drops cyc in WAIT while the target acks
        request(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        stb = 1'b0;
        tick();
        check("abort_mcyc_wait", {30'b0, m_cyc}, 32'h1);
        check("abort_mstb_wait", {30'b0, m_stb}, 32'h0);
        cyc = 1'b0;
        m_ack = 2'b01;
        tick();
        m_ack = 2'b00;
        check("abort_mcyc", {30'b0, m_cyc}, 32'h0);
        check("abort_ack", {31'b0, ack}, 32'h0);
        check("abort_err", {31'b0, err}, 32'h0);
        check("abort_stall", {31'b0, stall}, 32'h0);
        tick();
        check("abort_ack_late", {31'b0, ack | err}, 32'h0);

        // Reset mid-WAIT clears channels without a clock edge
        request(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        stb = 1'b0;
        tick();
        check("rstw_mcyc_before", {30'b0, m_cyc}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_mcyc_async", {30'b0, m_cyc}, 32'h0);
        check("rstw_stall_async", {31'b0, stall}, 32'h0);
        cyc = 1'b0;
        tick();
        rst = 1'b0;
        check("rstw_ack", {31'b0, ack | err}, 32'h0);
        tick();

        // Recovery transaction completes normally
        request(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        m_rdata[31:0] = 32'hCAFE_F00D;
        m_ack = 2'b01;
        tick();
        stb = 1'b0;
        check("rec_mstb", {30'b0, m_stb}, 32'h1);
        tick();
        check("rec_ack", {31'b0, ack}, 32'h1);
        check("rec_data", rdata, 32'hCAFE_F00D);
        m_ack = 2'b00;
        cyc = 1'b0;
        tick();
        check("rec_idle", {31'b0, ack | err | stall}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
